// File: rtl/shared_mac_dot_if.sv
// Operand/result bundle for the shared-multiplier dot-product engine.
// The master drives operands and start; the slave returns status and result.
interface shared_mac_dot_if #(
    parameter int WIDTH     = 32,
    parameter int N         = 4,
    parameter int ACC_WIDTH = 64
);
    logic                 start;
    logic                 mode_signed;
    logic [N*WIDTH-1:0]   w_flat;
    logic [N*WIDTH-1:0]   x_flat;
    logic                 busy;
    logic                 done;
    logic [ACC_WIDTH-1:0] out;
    logic                 ovf;

    modport master (
        output start, mode_signed, w_flat, x_flat,
        input  busy, done, out, ovf
    );

    modport slave (
        input  start, mode_signed, w_flat, x_flat,
        output busy, done, out, ovf
    );
endinterface

// File: rtl/shared_mac_dot.sv
// Dot product of N element pairs through one time-shared multiplier and adder.
// Products are pipelined one cycle ahead of the accumulate.
module shared_mac_dot #(
    parameter int WIDTH     = 32,
    parameter int N         = 4,
    parameter int ACC_WIDTH = 64
) (
    input logic             clk,
    input logic             rstb,
    shared_mac_dot_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;
    localparam int M  = ACC_WIDTH - 1;

    generate
        if (ACC_WIDTH < PW) begin : g_bad_acc
            $error("ACC_WIDTH must be at least 2*WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, MUL, DRAIN} state_t;

    state_t               r_state;
    logic [N*WIDTH-1:0]   r_wf;
    logic [N*WIDTH-1:0]   r_xf;
    logic                 r_sgn;
    logic [IW-1:0]        r_idx;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_prod;
    logic                 r_vld;
    logic                 r_ovf_acc;
    logic [ACC_WIDTH-1:0] r_out;
    logic                 r_ovf;
    logic                 r_busy;
    logic                 r_done;

    logic [WIDTH-1:0]     w_wi;
    logic [WIDTH-1:0]     w_xi;
    logic signed [PW-1:0] w_ps;
    logic [PW-1:0]        w_pu;
    logic [ACC_WIDTH-1:0] w_prod;
    logic [ACC_WIDTH:0]   w_sum_c;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_ovf_add;

    assign w_wi = r_wf[r_idx*WIDTH +: WIDTH];
    assign w_xi = r_xf[r_idx*WIDTH +: WIDTH];
    assign w_ps = PW'($signed(w_wi)) * PW'($signed(w_xi));
    assign w_pu = PW'(w_wi) * PW'(w_xi);
    assign w_prod = r_sgn ? ACC_WIDTH'(w_ps) : ACC_WIDTH'(w_pu);

    // Unsigned overflow is the carry; signed is a sign flip on like-signed operands.
    assign w_sum_c = {1'b0, r_acc} + {1'b0, r_prod};
    assign w_sum   = w_sum_c[M:0];
    assign w_ovf_add = r_sgn
        ? ((r_acc[M] == r_prod[M]) && (w_sum[M] != r_acc[M]))
        : w_sum_c[ACC_WIDTH];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state   <= IDLE;
            r_wf      <= '0;
            r_xf      <= '0;
            r_sgn     <= 1'b0;
            r_idx     <= '0;
            r_acc     <= '0;
            r_prod    <= '0;
            r_vld     <= 1'b0;
            r_ovf_acc <= 1'b0;
            r_out     <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_wf      <= bus.w_flat;
                        r_xf      <= bus.x_flat;
                        r_sgn     <= bus.mode_signed;
                        r_acc     <= '0;
                        r_ovf_acc <= 1'b0;
                        r_idx     <= '0;
                        r_vld     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= MUL;
                    end
                end
                MUL: begin
                    r_prod <= w_prod;
                    r_vld  <= 1'b1;
                    if (r_vld) begin
                        r_acc     <= w_sum;
                        r_ovf_acc <= r_ovf_acc | w_ovf_add;
                    end
                    if (r_idx == IW'(N - 1)) begin
                        r_state <= DRAIN;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DRAIN: begin
                    r_out   <= w_sum;
                    r_ovf   <= r_ovf_acc | w_ovf_add;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_vld   <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.out  = r_out;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_shared_mac_dot.sv
// Randomised bench for shared_mac_dot: three parameterisations checked
// against an arbitrary-precision reference of the dot product.
module tb_shared_mac_dot;
    logic clk = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    shared_mac_dot_if #(.WIDTH(32), .N(4), .ACC_WIDTH(64)) ia ();
    shared_mac_dot_if #(.WIDTH(32), .N(4), .ACC_WIDTH(66)) ib ();
    shared_mac_dot_if #(.WIDTH(8),  .N(1), .ACC_WIDTH(16)) ic ();

    shared_mac_dot #(.WIDTH(32), .N(4), .ACC_WIDTH(64)) u_a (
        .clk(clk), .rstb(rstb), .bus(ia.slave));
    shared_mac_dot #(.WIDTH(32), .N(4), .ACC_WIDTH(66)) u_b (
        .clk(clk), .rstb(rstb), .bus(ib.slave));
    shared_mac_dot #(.WIDTH(8),  .N(1), .ACC_WIDTH(16)) u_c (
        .clk(clk), .rstb(rstb), .bus(ic.slave));

    int checks = 0;
    int fails  = 0;
    int aw_t[3] = '{64, 66, 16};
    int wd_t[3] = '{32, 32, 8};
    int n_t[3]  = '{4, 4, 1};
    logic [135:0] last_out[3];
    bit           last_ov[3];

    task automatic chk(input string tag, input logic [135:0] got,
                       input logic [135:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic signed [135:0] ext(input logic [31:0] v,
                                                input int wd, input bit sg);
        logic signed [135:0] r;
        r = '0;
        for (int b = 0; b < wd; b++) r[b] = v[b];
        if (sg && v[wd-1]) r = r - (136'sd1 <<< wd);
        return r;
    endfunction

    // Exact running sum; an add overflows when its true value is not
    // representable in aw bits under the chosen interpretation.
    task automatic model(input int id, input bit sg,
                         input logic [31:0] w[4], input logic [31:0] x[4],
                         output logic [135:0] res, output bit ov);
        logic signed [135:0] acc, t, lo, hi;
        int aw, wd;
        aw = aw_t[id];
        wd = wd_t[id];
        acc = '0;
        ov = 1'b0;
        res = '0;
        lo = sg ? -(136'sd1 <<< (aw - 1)) : 136'sd0;
        hi = sg ? (136'sd1 <<< (aw - 1)) : (136'sd1 <<< aw);
        for (int i = 0; i < n_t[id]; i++) begin
            t = acc + ext(w[i], wd, sg) * ext(x[i], wd, sg);
            if (t < lo || t >= hi) ov = 1'b1;
            res = '0;
            for (int b = 0; b < aw; b++) res[b] = t[b];
            acc = res;
            if (sg && res[aw-1]) acc = acc - (136'sd1 <<< aw);
        end
    endtask

    task automatic set_in(input int id, input bit st, input bit sg,
                          input logic [31:0] w[4], input logic [31:0] x[4]);
        case (id)
            0: begin
                ia.start = st;
                ia.mode_signed = sg;
                for (int i = 0; i < 4; i++) begin
                    ia.w_flat[i*32 +: 32] = w[i];
                    ia.x_flat[i*32 +: 32] = x[i];
                end
            end
            1: begin
                ib.start = st;
                ib.mode_signed = sg;
                for (int i = 0; i < 4; i++) begin
                    ib.w_flat[i*32 +: 32] = w[i];
                    ib.x_flat[i*32 +: 32] = x[i];
                end
            end
            default: begin
                ic.start = st;
                ic.mode_signed = sg;
                ic.w_flat = w[0][7:0];
                ic.x_flat = x[0][7:0];
            end
        endcase
    endtask

    task automatic get_out(input int id, output bit bz, output bit dn,
                           output bit ov, output logic [135:0] o);
        case (id)
            0: begin bz = ia.busy; dn = ia.done; ov = ia.ovf; o = 136'(ia.out); end
            1: begin bz = ib.busy; dn = ib.done; ov = ib.ovf; o = 136'(ib.out); end
            default: begin
                bz = ic.busy; dn = ic.done; ov = ic.ovf; o = 136'(ic.out);
            end
        endcase
    endtask

    // b2b: caller sits at the falling edge of the previous done cycle.
    task automatic run_op(input int id, input bit sg,
                          input logic [31:0] w[4], input logic [31:0] x[4],
                          input bit junk, input bit b2b,
                          output logic [135:0] o, output bit ov);
        logic [135:0] eo, so;
        bit eov, bz, dn, sov;
        logic [31:0] rw[4], rx[4];
        int n;
        n = n_t[id];
        model(id, sg, w, x, eo, eov);
        if (!b2b) begin
            @(posedge clk); #1;
            get_out(id, bz, dn, sov, so);
            chk("hold_out", so, last_out[id]);
            chk("hold_ovf", 136'(sov), 136'(last_ov[id]));
            chk("idle_busy", 136'(bz), 136'(0));
        end
        set_in(id, 1'b1, sg, w, x);
        @(posedge clk); #1;
        if (junk) begin
            for (int i = 0; i < 4; i++) begin
                rw[i] = $urandom;
                rx[i] = $urandom;
            end
            set_in(id, 1'b1, ~sg, rw, rx);
        end else begin
            set_in(id, 1'b0, sg, w, x);
        end
        o = '0;
        ov = 1'b0;
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clk);
            get_out(id, bz, dn, sov, so);
            chk($sformatf("busy_id%0d_c%0d", id, k), 136'(bz), 136'(k <= n + 1));
            chk($sformatf("done_id%0d_c%0d", id, k), 136'(dn), 136'(k == n + 2));
            if (k == n + 1) set_in(id, 1'b0, sg, w, x);
            if (k == n + 2) begin
                chk($sformatf("out_id%0d", id), so, eo);
                chk($sformatf("ovf_id%0d", id), 136'(sov), 136'(eov));
                o = so;
                ov = sov;
            end
        end
        last_out[id] = eo;
        last_ov[id] = eov;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] w[4], x[4];
        logic [135:0] o, so;
        bit ov, bz, dn, sov, sg, jk, bb;
        int id, prev_id;

        w = '{0, 0, 0, 0};
        x = '{0, 0, 0, 0};
        for (int i = 0; i < 3; i++) begin
            set_in(i, 1'b0, 1'b0, w, x);
            last_out[i] = '0;
            last_ov[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            get_out(i, bz, dn, sov, so);
            chk("rst_busy", 136'(bz), 136'(0));
            chk("rst_done", 136'(dn), 136'(0));
            chk("rst_out", so, 136'(0));
            chk("rst_ovf", 136'(sov), 136'(0));
        end
        rstb = 1'b1;

        w = '{1, 2, 3, 4};
        x = '{5, 6, 7, 8};
        run_op(0, 1'b0, w, x, 1'b0, 1'b0, o, ov);
        chk("u_dot70", o, 136'd70);
        chk("u_dot70_ovf", 136'(ov), 136'(0));

        // -5 - 12 - 21 + 32 = -6
        w = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFD, 32'd4};
        x = '{32'd5, 32'hFFFF_FFFA, 32'd7, 32'd8};
        run_op(0, 1'b1, w, x, 1'b0, 1'b0, o, ov);
        chk("s_dot", o, 136'h0000_FFFF_FFFF_FFFF_FFFA);
        chk("s_dot_ovf", 136'(ov), 136'(0));

        w = '{4{32'hFFFF_FFFF}};
        x = '{4{32'hFFFF_FFFF}};
        run_op(0, 1'b0, w, x, 1'b0, 1'b0, o, ov);
        chk("u_max64", o, 136'hFFFF_FFF8_0000_0004);
        chk("u_max64_ovf", 136'(ov), 136'(1));
        run_op(1, 1'b0, w, x, 1'b0, 1'b0, o, ov);
        chk("u_max66", o, 136'h3_FFFF_FFF8_0000_0004);
        chk("u_max66_ovf", 136'(ov), 136'(0));

        w = '{1, 2, 3, 4};
        x = '{5, 6, 7, 8};
        run_op(0, 1'b0, w, x, 1'b1, 1'b0, o, ov);
        chk("junk_dot70", o, 136'd70);
        w = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFD, 32'd4};
        x = '{32'd5, 32'hFFFF_FFFA, 32'd7, 32'd8};
        run_op(0, 1'b1, w, x, 1'b0, 1'b1, o, ov);
        chk("b2b_dot", o, 136'h0000_FFFF_FFFF_FFFF_FFFA);

        w = '{1, 2, 3, 4};
        x = '{5, 6, 7, 8};
        @(posedge clk); #1;
        set_in(0, 1'b1, 1'b0, w, x);
        @(posedge clk); #1;
        set_in(0, 1'b0, 1'b0, w, x);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rstb = 1'b0;
        #1;
        get_out(0, bz, dn, sov, so);
        chk("abort_busy", 136'(bz), 136'(0));
        chk("abort_out", so, 136'(0));
        chk("abort_done", 136'(dn), 136'(0));
        @(negedge clk);
        rstb = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            get_out(0, bz, dn, sov, so);
            chk("abort_nodone", 136'(dn), 136'(0));
            chk("abort_idle", 136'(bz), 136'(0));
        end
        for (int i = 0; i < 3; i++) begin
            last_out[i] = '0;
            last_ov[i] = 1'b0;
        end
        run_op(0, 1'b0, w, x, 1'b0, 1'b0, o, ov);
        chk("post_abort", o, 136'd70);

        w = '{32'h80, 0, 0, 0};
        x = '{32'h02, 0, 0, 0};
        run_op(2, 1'b1, w, x, 1'b0, 1'b0, o, ov);
        chk("n1_signed", o, 136'hFF00);
        chk("n1_signed_ovf", 136'(ov), 136'(0));
        run_op(2, 1'b0, w, x, 1'b0, 1'b0, o, ov);
        chk("n1_unsigned", o, 136'h0100);

        prev_id = 2;
        for (int it = 0; it < 40; it++) begin
            id = $urandom_range(0, 2);
            sg = 1'($urandom);
            jk = ($urandom_range(0, 3) == 0);
            bb = (id == prev_id) && ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 4; i++) begin
                w[i] = pick();
                x[i] = pick();
            end
            run_op(id, sg, w, x, jk, bb, o, ov);
            prev_id = id;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
